mc_exec_unit: RTL and testbench
===============================

MC_EXEC_UNIT -- requirements
Module: mc_exec_unit

Interface
REQ-001 Parameter DATA_W, default 16, datapath and register width (legal 16..32).
REQ-002 Parameter NREG, default 8, register count (power of 2, max 8; 3-bit fields index it modulo NREG).
REQ-003 Parameter MEM_TIMEOUT, default 15, cycles to wait for mem_ack before aborting.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 instr_valid / instr_ready  in/out  1  instruction handshake; accepted when both high on a clk edge.
REQ-007 instr  in  16  op[15:13], ra[12:10], rb[9:7], rc[2:0], imm7[6:0], imm10[9:0].
REQ-008 pc_in  in  DATA_W  PC of offered instruction, sampled with instr.
REQ-009 pc_out / pc_valid  out  DATA_W/1  next PC, pc_valid one-cycle pulse at retire.
REQ-010 mem_req, mem_we  out  1  memory request strobe (held until ack or abort), write enable.
REQ-011 mem_addr, mem_wdata  out  DATA_W  memory address, store data.
REQ-012 mem_ack / mem_rdata  in  1/DATA_W  memory completion and load data.
REQ-013 mem_err  out  1  one-cycle pulse on timeout abort.
REQ-014 dbg_sel / dbg_data  in 3 / out DATA_W  combinational register read port.

Function
REQ-015 FSM states IDLE, EXEC, MEM, WB; IDLE->EXEC on accept; EXEC->MEM for SW/LW, else EXEC->WB; MEM->WB on mem_ack or timeout; WB->IDLE.
REQ-016 instr_ready high only in IDLE and not in reset.
REQ-017 Instruction, pc_in, and register operands are latched at accept; later changes to inputs do not affect the in-flight op.
REQ-018 Ops: ADD ra=rb+rc; ADDI ra=rb+sext(imm7); SUBI ra=rb-sext(imm7); BEQ if ra==rb pc_out=pc+1+sext(imm7); JALR ra=pc+1, pc_out=rb; LUI ra={imm10, DATA_W-10 zeros}; SW/LW address rb+sext(imm7).
REQ-019 All arithmetic is modulo 2^DATA_W; no overflow flag.
REQ-020 Default pc_out=pc+1 for every op not redirecting.
REQ-021 SW: mem_addr={2'b01, sum[DATA_W-3:0]}, mem_we=1, mem_wdata=ra; LW: mem_addr={2'b10, sum[DATA_W-3:0]}, mem_we=0.
REQ-022 LW writes mem_rdata captured on the mem_ack cycle into ra.
REQ-023 Register write occurs in WB only, only for ADD, ADDI, SUBI, JALR, LUI, LW; never for BEQ, SW, or aborted LW.
REQ-024 Latency: non-memory op retires (pc_valid) 2 cycles after accept; memory op retires 1 cycle after mem_ack.
REQ-025 Timeout: counter starts on MEM entry; if MEM_TIMEOUT cycles elapse without ack, drop mem_req, pulse mem_err, retire with pc_out=pc+1, no writeback.
REQ-026 mem_ack outside MEM is ignored.
REQ-027 JALR with ra==rb: pc_out uses pre-write rb value.

Reset
REQ-028 rst forces IDLE, all registers 0, pc_out 0, pc_valid 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_err 0, timeout counter 0.
REQ-029 rst asserted mid-operation (including MEM) abandons the op without writeback and deasserts mem_req next edge.

Configuration
REQ-030 Macro MC_EXEC_ZERO_REG_EN defined: register 0 always reads 0 and writes to it are discarded; undefined: register 0 is a general register.

Structure
REQ-031 Shared package mc_exec_pkg holds opcode constants, FSM state enum, address-prefix constants.
REQ-032 One sub-module mc_exec_regfile (NREG x DATA_W, one write port, three read ports plus debug port).

Verification
REQ-033 ADDI r1,r0,5 then ADD r2,r1,r1 -> dbg r2=10, each pc_valid 2 cycles after accept, pc_out=pc_in+1.
REQ-034 r1=3, SUBI r3,r1,5 -> r3=0xFFFE (DATA_W=16).
REQ-035 BEQ r1,r1,imm7=0x7E at pc_in=0x0010 -> pc_out=0x000F, no register changes.
REQ-036 SW r2 to rb=r0 imm7=4, ack after 3 cycles -> mem_addr=0x4004, mem_wdata=10, mem_we=1, retire 1 cycle after ack.
REQ-037 LW with no ack, MEM_TIMEOUT=15 -> mem_err pulse after 15 cycles, ra unchanged, pc_out=pc_in+1.
REQ-038 ADDI r0,r0,7 -> dbg r0=0 with MC_EXEC_ZERO_REG_EN, 7 without; rst during MEM -> IDLE, mem_req=0 next cycle.

Source files
------------

// File: rtl/mc_exec_pkg.sv
// ============================================================================
// Module      : mc_exec_pkg
// Description : Shared definitions for the multi-cycle execution unit:
//               opcode encodings, FSM state type and memory address prefixes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mc_exec_pkg;

    // Opcode field instr[15:13]
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_SUBI = 3'd2;
    localparam logic [2:0] OP_BEQ  = 3'd3;
    localparam logic [2:0] OP_JALR = 3'd4;
    localparam logic [2:0] OP_LUI  = 3'd5;
    localparam logic [2:0] OP_SW   = 3'd6;
    localparam logic [2:0] OP_LW   = 3'd7;

    // Top two bits of the memory address select the store or load window
    localparam logic [1:0] ADDR_PFX_SW = 2'b01;
    localparam logic [1:0] ADDR_PFX_LW = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MEM  = 2'd2,
        ST_WB   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mc_exec_regfile.sv
// ============================================================================
// Module      : mc_exec_regfile
// Description : NREG x DATA_W register file, one write port, three
//               combinational read ports plus a combinational debug port.
//               3-bit register selects are taken modulo NREG.
// Config      : MC_EXEC_ZERO_REG_EN - register 0 reads as zero and ignores
//               writes; otherwise register 0 is a general register.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               i_we/i_waddr/i_wdata - write port
//               i_raddr_[abc]/o_rdata_[abc] - operand read ports
//               i_dbg_sel/o_dbg_data - debug read port
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_exec_regfile #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [2:0]        i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [2:0]        i_raddr_a,
    input  logic [2:0]        i_raddr_b,
    input  logic [2:0]        i_raddr_c,
    input  logic [2:0]        i_dbg_sel,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b,
    output logic [DATA_W-1:0] o_rdata_c,
    output logic [DATA_W-1:0] o_dbg_data
);

    localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;

    logic [DATA_W-1:0] r_regs [NREG];
    logic [AW-1:0]     w_widx;
    logic              w_we_eff;

    // Low select bits give the modulo-NREG index (NREG is a power of two)
    function automatic logic [DATA_W-1:0] rd(input logic [2:0] sel);
        logic [AW-1:0] idx;
        idx = sel[AW-1:0];
`ifdef MC_EXEC_ZERO_REG_EN
        if (idx == '0) begin
            return '0;
        end
`endif
        return r_regs[idx];
    endfunction

    assign w_widx = i_waddr[AW-1:0];

`ifdef MC_EXEC_ZERO_REG_EN
    assign w_we_eff = i_we && (w_widx != '0);
`else
    assign w_we_eff = i_we;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we_eff) begin
            r_regs[w_widx] <= i_wdata;
        end
    end

    assign o_rdata_a  = rd(i_raddr_a);
    assign o_rdata_b  = rd(i_raddr_b);
    assign o_rdata_c  = rd(i_raddr_c);
    assign o_dbg_data = rd(i_dbg_sel);

endmodule

`default_nettype wire

// File: rtl/mc_exec_unit.sv
// ============================================================================
// Module      : mc_exec_unit
// Description : Multi-cycle execution unit IDLE->EXEC->(MEM)->WB.
//               Instruction, PC and operands are latched at accept; memory
//               ops wait for mem_ack with a MEM_TIMEOUT abort.
// Config      : MC_EXEC_ZERO_REG_EN (see mc_exec_regfile) - hard-wired r0.
// Ports       : clk, rst                  - clock, sync active-high reset
//               instr_valid/instr_ready   - instruction handshake
//               instr, pc_in              - instruction and its PC
//               pc_out, pc_valid          - next PC, retire pulse
//               mem_req/we/addr/wdata     - memory request
//               mem_ack, mem_rdata        - memory response
//               mem_err                   - timeout abort pulse
//               dbg_sel, dbg_data         - debug register read
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_exec_unit
    import mc_exec_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int NREG        = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    input  logic [DATA_W-1:0] pc_in,
    output logic [DATA_W-1:0] pc_out,
    output logic              pc_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_err,
    input  logic [2:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t            r_state, w_next;
    logic [15:0]       r_instr;
    logic [DATA_W-1:0] r_pc, r_va, r_vb, r_vc;
    logic [DATA_W-1:0] r_result, r_pc_next, r_pc_out;
    logic              r_wr_en;
    logic [TW-1:0]     r_tmo;
    logic              r_mem_req, r_mem_we, r_mem_err, r_pc_valid;
    logic [DATA_W-1:0] r_mem_addr, r_mem_wdata;

    logic              w_accept, w_tmo, w_rf_we;
    logic [2:0]        w_op;
    logic [DATA_W-1:0] w_sx7, w_pc1, w_sum;
    logic [DATA_W-1:0] w_result, w_pc_sel;
    logic              w_wr, w_is_mem;
    logic [DATA_W-1:0] w_rd_a, w_rd_b, w_rd_c;

    assign instr_ready = (r_state == ST_IDLE) && !rst;
    assign w_accept    = instr_valid && instr_ready;
    assign w_op        = r_instr[15:13];
    assign w_sx7       = {{(DATA_W-7){r_instr[6]}}, r_instr[6:0]};
    assign w_pc1       = r_pc + DATA_W'(1);
    assign w_sum       = r_vb + w_sx7;
    // Abort on the edge that completes MEM_TIMEOUT cycles in MEM without ack
    assign w_tmo       = (r_state == ST_MEM) && !mem_ack &&
                         (r_tmo == TW'(MEM_TIMEOUT - 1));

    mc_exec_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_rf_we),
        .i_waddr    (r_instr[12:10]),
        .i_wdata    (r_result),
        .i_raddr_a  (instr[12:10]),
        .i_raddr_b  (instr[9:7]),
        .i_raddr_c  (instr[2:0]),
        .i_dbg_sel  (dbg_sel),
        .o_rdata_a  (w_rd_a),
        .o_rdata_b  (w_rd_b),
        .o_rdata_c  (w_rd_c),
        .o_dbg_data (dbg_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and register-file write strobe
    always_comb begin
        w_next  = r_state;
        w_rf_we = 1'b0;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_EXEC;
            ST_EXEC: w_next = w_is_mem ? ST_MEM : ST_WB;
            ST_MEM:  if (mem_ack || w_tmo) w_next = ST_WB;
            ST_WB: begin
                w_next  = ST_IDLE;
                w_rf_we = r_wr_en;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operation decode on the latched instruction
    always_comb begin
        w_result = '0;
        w_pc_sel = w_pc1;
        w_wr     = 1'b0;
        w_is_mem = 1'b0;
        case (w_op)
            OP_ADD:  begin w_result = r_vb + r_vc;  w_wr = 1'b1; end
            OP_ADDI: begin w_result = r_vb + w_sx7; w_wr = 1'b1; end
            OP_SUBI: begin w_result = r_vb - w_sx7; w_wr = 1'b1; end
            OP_BEQ:  if (r_va == r_vb) w_pc_sel = w_pc1 + w_sx7;
            // Operands were latched at accept, so ra==rb still jumps to old rb
            OP_JALR: begin w_result = w_pc1; w_pc_sel = r_vb; w_wr = 1'b1; end
            OP_LUI:  begin
                w_result = {r_instr[9:0], {(DATA_W-10){1'b0}}};
                w_wr     = 1'b1;
            end
            OP_SW:   w_is_mem = 1'b1;
            OP_LW:   begin w_is_mem = 1'b1; w_wr = 1'b1; end
            default: w_wr = 1'b0;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr     <= '0;
            r_pc        <= '0;
            r_va        <= '0;
            r_vb        <= '0;
            r_vc        <= '0;
            r_result    <= '0;
            r_pc_next   <= '0;
            r_pc_out    <= '0;
            r_wr_en     <= 1'b0;
            r_tmo       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_err   <= 1'b0;
            r_pc_valid  <= 1'b0;
        end else begin
            r_pc_valid <= 1'b0;
            r_mem_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_instr <= instr;
                        r_pc    <= pc_in;
                        r_va    <= w_rd_a;
                        r_vb    <= w_rd_b;
                        r_vc    <= w_rd_c;
                    end
                end
                ST_EXEC: begin
                    r_result  <= w_result;
                    r_pc_next <= w_pc_sel;
                    r_wr_en   <= w_wr;
                    r_tmo     <= '0;
                    if (w_is_mem) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= (w_op == OP_SW);
                        r_mem_addr  <= {(w_op == OP_SW) ? ADDR_PFX_SW : ADDR_PFX_LW,
                                        w_sum[DATA_W-3:0]};
                        r_mem_wdata <= r_va;
                    end
                end
                ST_MEM: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_result  <= mem_rdata;
                    end else if (w_tmo) begin
                        r_mem_req <= 1'b0;
                        r_mem_err <= 1'b1;
                        r_wr_en   <= 1'b0;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                ST_WB: begin
                    r_pc_valid <= 1'b1;
                    r_pc_out   <= r_pc_next;
                end
                default: r_pc_valid <= 1'b0;
            endcase
        end
    end

    assign pc_out    = r_pc_out;
    assign pc_valid  = r_pc_valid;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_err   = r_mem_err;

endmodule

`default_nettype wire

// File: tb/tb_mc_exec_unit.sv
// ============================================================================
// Module      : tb_mc_exec_unit
// Description : Directed self-checking bench for mc_exec_unit (DATA_W=16,
//               NREG=8, MEM_TIMEOUT=15). Honors MC_EXEC_ZERO_REG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_exec_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic [15:0] pc_in = '0;
    logic [15:0] pc_out;
    logic        pc_valid;
    logic        mem_req, mem_we, mem_err;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [2:0]  dbg_sel = '0;
    logic [15:0] dbg_data;

    int n_total = 0;
    int n_bad   = 0;

    mc_exec_unit #(.DATA_W(16), .NREG(8), .MEM_TIMEOUT(15)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .pc_in       (pc_in),
        .pc_out      (pc_out),
        .pc_valid    (pc_valid),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .mem_err     (mem_err),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] sel, input logic [15:0] exp);
        dbg_sel = sel;
        #1;
        chk(tag, {16'h0, dbg_data}, {16'h0, exp});
    endtask

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] ra,
                                        input logic [2:0] rb, input logic [6:0] imm);
        return {op, ra, rb, imm};
    endfunction

    // Offer an instruction; returns 1 time unit after the accepting edge
    task automatic issue(input logic [15:0] ins, input logic [15:0] pc);
        int n;
        n = 0;
        @(negedge clk);
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
        instr       = ins;
        pc_in       = pc;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr       = 16'hFFFF;   // later input changes must not matter
        pc_in       = 16'hDEAD;
    endtask

    task automatic wait_retire(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!pc_valid && lat < 50);
    endtask

    task automatic wait_req(output int n);
        n = 0;
        while (!mem_req && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Non-memory op: check latency and next PC
    task automatic run_op(input string tag, input logic [15:0] ins,
                          input logic [15:0] pc, input logic [15:0] exp_pc);
        int lat;
        issue(ins, pc);
        wait_retire(lat);
        chk({tag, "_lat"}, lat, 32'd2);
        chk({tag, "_pc"}, {16'h0, pc_out}, {16'h0, exp_pc});
    endtask

    initial begin
        int n;

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, instr_ready}, 32'd0);
        chk("rst_pc_out", {16'h0, pc_out}, 32'h0);
        chk("rst_pc_valid", {31'h0, pc_valid}, 32'd0);
        chk("rst_mem_req", {31'h0, mem_req}, 32'd0);
        chk("rst_mem_addr", {16'h0, mem_addr}, 32'h0);
        chk("rst_mem_err", {31'h0, mem_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_ready", {31'h0, instr_ready}, 32'd1);
        chk_reg("rst_r1", 3'd1, 16'h0);

        // ---------------- ALU ops ----------------
        run_op("addi", enc(3'd1, 3'd1, 3'd0, 7'd5), 16'h0020, 16'h0021);
        chk_reg("addi_r1", 3'd1, 16'd5);
        run_op("add", {3'd0, 3'd2, 3'd1, 4'd0, 3'd1}, 16'h0021, 16'h0022);
        chk_reg("add_r2", 3'd2, 16'd10);

        // mem_ack held high outside MEM must be ignored
        mem_ack = 1'b1;
        run_op("addi3", enc(3'd1, 3'd1, 3'd0, 7'd3), 16'h0022, 16'h0023);
        chk("stray_ack_req", {31'h0, mem_req}, 32'd0);
        mem_ack = 1'b0;
        chk_reg("addi3_r1", 3'd1, 16'd3);

        run_op("subi", enc(3'd2, 3'd3, 3'd1, 7'd5), 16'h0023, 16'h0024);
        chk_reg("subi_r3", 3'd3, 16'hFFFE);

        // ---------------- branches / jumps ----------------
        run_op("beq_t", enc(3'd3, 3'd1, 3'd1, 7'h7E), 16'h0010, 16'h000F);
        chk_reg("beq_r1", 3'd1, 16'd3);
        chk_reg("beq_r3", 3'd3, 16'hFFFE);
        run_op("beq_nt", enc(3'd3, 3'd1, 3'd2, 7'd5), 16'h0030, 16'h0031);

        run_op("addi_r4", enc(3'd1, 3'd4, 3'd0, 7'h3F), 16'h0040, 16'h0041);
        run_op("jalr", enc(3'd4, 3'd4, 3'd4, 7'd0), 16'h0100, 16'h003F);
        chk_reg("jalr_r4", 3'd4, 16'h0101);

        run_op("lui", {3'd5, 3'd5, 10'h2AB}, 16'h0200, 16'h0201);
        chk_reg("lui_r5", 3'd5, 16'hAAC0);

        // ---------------- SW with ack after 3 cycles ----------------
        issue(enc(3'd6, 3'd2, 3'd0, 7'd4), 16'h0050);
        wait_req(n);
        chk("sw_req_lat", n, 32'd1);
        chk("sw_addr", {16'h0, mem_addr}, 32'h4004);
        chk("sw_wdata", {16'h0, mem_wdata}, 32'd10);
        chk("sw_we", {31'h0, mem_we}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("sw_req_hold", {31'h0, mem_req}, 32'd1);
        @(negedge clk);
        mem_ack = 1'b1;
        @(posedge clk);
        #1;
        chk("sw_req_drop", {31'h0, mem_req}, 32'd0);
        chk("sw_not_yet", {31'h0, pc_valid}, 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        @(posedge clk);
        #1;
        chk("sw_retire", {31'h0, pc_valid}, 32'd1);
        chk("sw_pc", {16'h0, pc_out}, 32'h0051);
        chk_reg("sw_r2", 3'd2, 16'd10);

        // ---------------- LW with ack ----------------
        issue(enc(3'd7, 3'd6, 3'd2, 7'h7E), 16'h0060);
        wait_req(n);
        chk("lw_addr", {16'h0, mem_addr}, 32'h8008);
        chk("lw_we", {31'h0, mem_we}, 32'd0);
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 16'h1234;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 16'h0BAD;
        @(posedge clk);
        #1;
        chk("lw_retire", {31'h0, pc_valid}, 32'd1);
        chk("lw_pc", {16'h0, pc_out}, 32'h0061);
        chk_reg("lw_r6", 3'd6, 16'h1234);

        // ---------------- LW timeout ----------------
        issue(enc(3'd7, 3'd6, 3'd0, 7'd1), 16'h0070);
        wait_req(n);
        n = 0;
        while (!mem_err && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("tmo_cycles", n, 32'd15);
        chk("tmo_req", {31'h0, mem_req}, 32'd0);
        @(posedge clk);
        #1;
        chk("tmo_err_pulse", {31'h0, mem_err}, 32'd0);
        chk("tmo_retire", {31'h0, pc_valid}, 32'd1);
        chk("tmo_pc", {16'h0, pc_out}, 32'h0071);
        chk_reg("tmo_r6", 3'd6, 16'h1234);

        // ---------------- register 0 behaviour ----------------
        run_op("addi_r0", enc(3'd1, 3'd0, 3'd0, 7'd7), 16'h0080, 16'h0081);
`ifdef MC_EXEC_ZERO_REG_EN
        chk_reg("r0", 3'd0, 16'd0);
`else
        chk_reg("r0", 3'd0, 16'd7);
`endif

        // ---------------- reset during MEM ----------------
        issue(enc(3'd6, 3'd2, 3'd0, 7'd4), 16'h0090);
        wait_req(n);
        chk("mrst_req_up", {31'h0, mem_req}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_req", {31'h0, mem_req}, 32'd0);
        chk("mrst_pc_valid", {31'h0, pc_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_ready", {31'h0, instr_ready}, 32'd1);
        chk_reg("mrst_r2", 3'd2, 16'h0);
        chk("mrst_pc_out", {16'h0, pc_out}, 32'h0);
        run_op("post_rst", enc(3'd1, 3'd1, 3'd0, 7'd1), 16'h00A0, 16'h00A1);
        chk_reg("post_rst_r1", 3'd1, 16'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
